// File: rtl/rr_mux_arbiter4_if.sv
// Bundle of request, data and downstream handshake signals for rr_mux_arbiter4.
// The arbiter uses the slave modport; the producer/consumer side uses master.
interface rr_mux_arbiter4_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] data3;
  logic             out_ready;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y;
  logic             out_valid;

  modport master (
    output req, data0, data1, data2, data3, out_ready,
    input  gnt, sel, y, out_valid
  );

  modport slave (
    input  req, data0, data1, data2, data3, out_ready,
    output gnt, sel, y, out_valid
  );
endinterface

// File: rtl/rr_mux_arbiter4.sv
// Four-requester round-robin arbiter feeding a registered mux with valid/ready output.
// Optional build macro ARB_FIXED_PRIORITY_EN switches to fixed lowest-index-wins priority.
module rr_mux_arbiter4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  rr_mux_arbiter4_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_next;
  logic [3:0]       gnt_q, gnt_next;
  logic [1:0]       sel_q, sel_next;
  logic [WIDTH-1:0] y_q, y_next;
  logic [WIDTH-1:0] mux_word;
  logic [1:0]       win_idx;
  logic             accept;

  assign accept = (state_q == HOLD) && bus.out_ready;

`ifdef ARB_FIXED_PRIORITY_EN
  // Lowest set index wins; scanning high to low lets the last hit be the lowest.
  always_comb begin
    win_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[i]) win_idx = 2'(i);
    end
  end
`else
  logic [1:0] last_q, last_next;
  logic [1:0] base;
  logic [1:0] cand;

  // In HOLD the pointer about to be committed is sel, so scan from sel+1.
  assign base = (state_q == HOLD) ? sel_q : last_q;

  always_comb begin
    win_idx = base + 2'd1;
    cand    = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = base + 2'(k);
      if (bus.req[cand]) win_idx = cand;
    end
  end

  always_comb begin
    last_next = last_q;
    if (accept) last_next = sel_q;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= 2'd3;
    else       last_q <= last_next;
  end
`endif

  always_comb begin
    mux_word = bus.data0;
    case (sel_q)
      2'd0:    mux_word = bus.data0;
      2'd1:    mux_word = bus.data1;
      2'd2:    mux_word = bus.data2;
      default: mux_word = bus.data3;
    endcase
  end

  always_comb begin
    state_next = state_q;
    gnt_next   = 4'b0000;
    sel_next   = sel_q;
    y_next     = y_q;
    case (state_q)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          sel_next   = win_idx;
          gnt_next   = 4'b0001 << win_idx;
          state_next = LOAD;
        end
      end
      LOAD: begin
        // The granted word is captured regardless of req; the requester is committed.
        y_next     = mux_word;
        state_next = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (bus.req != 4'b0000) begin
            sel_next   = win_idx;
            gnt_next   = 4'b0001 << win_idx;
            state_next = LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      y_q     <= '0;
    end else begin
      state_q <= state_next;
      gnt_q   <= gnt_next;
      sel_q   <= sel_next;
      y_q     <= y_next;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.y         = y_q;
  assign bus.out_valid = (state_q == HOLD);

endmodule
